// File: rtl/mips_pkg.sv
// Shared encodings for the memory arbiter: FSM states and grant identifiers.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_INIT  = 2'd1,
        GNT_DATA  = 2'd2,
        GNT_FETCH = 2'd3
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the three-way memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic              init_req;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              init_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic [1:0]        grant_id;

    // Arbiter side
    modport slave (
        input  init_req, init_addr, init_data,
        input  d_req, d_we, d_addr, d_wdata,
        input  if_req, if_addr,
        input  mem_rdata,
        output init_ack, d_ack, d_rdata, if_ack, if_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant_id
    );

    // Requesters plus memory side
    modport master (
        output init_req, init_addr, init_data,
        output d_req, d_we, d_addr, d_wdata,
        output if_req, if_addr,
        output mem_rdata,
        input  init_ack, d_ack, d_rdata, if_ack, if_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-requester single-port memory arbiter: IDLE -> ISSUE -> RESP, one access per 3 cycles.
// Define ARB_RR_EN for round-robin data/fetch tie-breaking; default is fixed data > fetch.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d;
    logic              we_q, we_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              init_ack_q, init_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              busy_q, busy_d;
    grant_t            grant_id_q, grant_id_d;

    grant_t            win_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              sel_we_c;
    logic              data_first_c;

`ifdef ARB_RR_EN
    // High means data wins the next data/fetch tie
    logic rr_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_data_q <= 1'b1;
        end else if (state_q == S_IDLE) begin
            if (win_c == GNT_DATA)       rr_data_q <= 1'b0;
            else if (win_c == GNT_FETCH) rr_data_q <= 1'b1;
        end
    end

    assign data_first_c = rr_data_q;
`else
    assign data_first_c = 1'b1;
`endif

    // Priority select: init always first, then data/fetch by tie-break policy
    always_comb begin
        win_c       = GNT_NONE;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_we_c    = 1'b0;
        if (bus.init_req) begin
            win_c       = GNT_INIT;
            sel_addr_c  = bus.init_addr;
            sel_wdata_c = bus.init_data;
            sel_we_c    = 1'b1;
        end else if (bus.d_req && (!bus.if_req || data_first_c)) begin
            win_c       = GNT_DATA;
            sel_addr_c  = bus.d_addr;
            sel_wdata_c = bus.d_wdata;
            sel_we_c    = bus.d_we;
        end else if (bus.if_req) begin
            win_c       = GNT_FETCH;
            sel_addr_c  = bus.if_addr;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        init_ack_d  = 1'b0;
        d_ack_d     = 1'b0;
        if_ack_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        if_rdata_d  = if_rdata_q;
        busy_d      = 1'b0;
        grant_id_d  = GNT_NONE;

        case (state_q)
            S_IDLE: begin
                if (win_c != GNT_NONE) begin
                    state_d     = S_ISSUE;
                    gnt_d       = win_c;
                    we_d        = sel_we_c;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we_c;
                    mem_addr_d  = sel_addr_c;
                    mem_wdata_d = sel_wdata_c;
                    busy_d      = 1'b1;
                    grant_id_d  = win_c;
                end
            end
            S_ISSUE: begin
                state_d    = S_RESP;
                busy_d     = 1'b1;
                grant_id_d = gnt_q;
            end
            S_RESP: begin
                state_d = S_IDLE;
                case (gnt_q)
                    GNT_INIT: init_ack_d = 1'b1;
                    GNT_DATA: begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = we_q ? '0 : bus.mem_rdata;
                    end
                    GNT_FETCH: begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= GNT_NONE;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            init_ack_q  <= 1'b0;
            d_ack_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            d_rdata_q   <= '0;
            if_rdata_q  <= '0;
            busy_q      <= 1'b0;
            grant_id_q  <= GNT_NONE;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            init_ack_q  <= init_ack_d;
            d_ack_q     <= d_ack_d;
            if_ack_q    <= if_ack_d;
            d_rdata_q   <= d_rdata_d;
            if_rdata_q  <= if_rdata_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.init_ack  = init_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = 2'(grant_id_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle synchronous-read memory.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes and reads both take effect at the edge mem_en is sampled
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where requests were set; returns at the negedge with ack visible
    task automatic expect_access(input string tag, input logic [1:0] gid, input logic [7:0] addr,
                                 input logic we, input logic [31:0] wdata, input logic [31:0] rdata);
        logic [2:0] exp_ack;
        exp_ack = {gid == 2'd1, gid == 2'd2, gid == 2'd3};
        @(negedge clk);
        chk({tag, ".issue_en"},    64'(bus.mem_en), 64'(1'b1));
        chk({tag, ".issue_we"},    64'(bus.mem_we), 64'(we));
        chk({tag, ".issue_addr"},  64'(bus.mem_addr), 64'(addr));
        chk({tag, ".issue_wdata"}, 64'(bus.mem_wdata), 64'(wdata));
        chk({tag, ".issue_busy"},  64'(bus.busy), 64'(1'b1));
        chk({tag, ".issue_gid"},   64'(bus.grant_id), 64'(gid));
        chk({tag, ".issue_acks"},  64'({bus.init_ack, bus.d_ack, bus.if_ack}), 64'(3'b000));
        @(negedge clk);
        chk({tag, ".resp_en"},     64'(bus.mem_en), 64'(1'b0));
        chk({tag, ".resp_busy"},   64'(bus.busy), 64'(1'b1));
        chk({tag, ".resp_gid"},    64'(bus.grant_id), 64'(gid));
        chk({tag, ".resp_acks"},   64'({bus.init_ack, bus.d_ack, bus.if_ack}), 64'(3'b000));
        @(negedge clk);
        chk({tag, ".ack"},         64'({bus.init_ack, bus.d_ack, bus.if_ack}), 64'(exp_ack));
        chk({tag, ".ack_busy"},    64'(bus.busy), 64'(1'b0));
        chk({tag, ".ack_gid"},     64'(bus.grant_id), 64'(2'd0));
        if (gid == 2'd2) chk({tag, ".d_rdata"},  64'(bus.d_rdata), 64'(rdata));
        if (gid == 2'd3) chk({tag, ".if_rdata"}, 64'(bus.if_rdata), 64'(rdata));
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b0;
        bus.init_req = 1'b0; bus.init_addr = '0; bus.init_data = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_rdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.outputs", 64'({bus.mem_en, bus.mem_we, bus.busy, bus.grant_id,
                                bus.init_ack, bus.d_ack, bus.if_ack}), 64'(8'h00));
        chk("rst.addr_wdata", 64'({bus.mem_addr, bus.mem_wdata}), 64'(0));
        chk("rst.rdata", 64'({bus.d_rdata, bus.if_rdata}), 64'(0));
        reset = 1'b1;

        // Idle with no requests stays idle
        @(negedge clk);
        chk("idle.busy", 64'({bus.busy, bus.mem_en}), 64'(2'b00));

        // Loader preloads 0x04 through the init port
        bus.init_req = 1'b1; bus.init_addr = 8'h04; bus.init_data = 32'h2001000A;
        expect_access("preload", 2'd1, 8'h04, 1'b1, 32'h2001000A, 32'h0);
        bus.init_req = 1'b0;

        // Single fetch
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 8'h04;
        expect_access("fetch1", 2'd3, 8'h04, 1'b0, 32'h0, 32'h2001000A);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("fetch1.ack_pulse", 64'(bus.if_ack), 64'(1'b0));
        chk("fetch1.rdata_hold", 64'(bus.if_rdata), 64'(32'h2001000A));

        // Simultaneous init, data and fetch: init, then data, then fetch
        bus.init_req = 1'b1; bus.init_addr = 8'h10; bus.init_data = 32'hDEADBEEF;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h04; bus.d_wdata = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 8'h10;
        expect_access("tri.init", 2'd1, 8'h10, 1'b1, 32'hDEADBEEF, 32'h0);
        bus.init_req = 1'b0;
        expect_access("tri.data", 2'd2, 8'h04, 1'b0, 32'h0, 32'h2001000A);
        bus.d_req = 1'b0;
        expect_access("tri.fetch", 2'd3, 8'h10, 1'b0, 32'h0, 32'hDEADBEEF);
        bus.if_req = 1'b0;

        // Data and fetch held together for four grants
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10; bus.d_wdata = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 8'h04;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            if (i % 2 == 1) expect_access($sformatf("hold%0d", i), 2'd3, 8'h04, 1'b0, 32'h0, 32'h2001000A);
            else            expect_access($sformatf("hold%0d", i), 2'd2, 8'h10, 1'b0, 32'h0, 32'hDEADBEEF);
`else
            expect_access($sformatf("hold%0d", i), 2'd2, 8'h10, 1'b0, 32'h0, 32'hDEADBEEF);
`endif
        end
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;

        // Store then load at 0x20
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 32'h12345678;
        expect_access("store", 2'd2, 8'h20, 1'b1, 32'h12345678, 32'h0);
        bus.d_we = 1'b0; bus.d_wdata = 32'h0;
        expect_access("load", 2'd2, 8'h20, 1'b0, 32'h0, 32'h12345678);
        bus.d_req = 1'b0;

        // Reset asserted during ISSUE drops the access; fetch is re-granted afterwards
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 8'h20;
        @(negedge clk);
        chk("rstmid.issue_en", 64'(bus.mem_en), 64'(1'b1));
        reset = 1'b0;
        #1;
        chk("rstmid.en_cleared", 64'(bus.mem_en), 64'(1'b0));
        chk("rstmid.status", 64'({bus.busy, bus.grant_id}), 64'(3'b000));
        chk("rstmid.rdata", 64'({bus.d_rdata, bus.if_rdata}), 64'(0));
        @(negedge clk);
        chk("rstmid.no_ack", 64'({bus.init_ack, bus.d_ack, bus.if_ack}), 64'(3'b000));
        @(negedge clk);
        chk("rstmid.no_ack2", 64'({bus.init_ack, bus.d_ack, bus.if_ack}), 64'(3'b000));
        reset = 1'b1;
        expect_access("regrant", 2'd3, 8'h20, 1'b0, 32'h0, 32'h12345678);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("final.idle", 64'({bus.busy, bus.if_ack}), 64'(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-005 SHALL have ports init_req input 1, init_addr input ADDR_W, init_data input DATA_W, init_ack output 1  loader write requester.
REQ-006 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W, d_wdata input DATA_W, d_ack output 1, d_rdata output DATA_W  data load/store requester.
REQ-007 SHALL have ports if_req input 1, if_addr input ADDR_W, if_ack output 1, if_rdata output DATA_W  instruction-fetch read requester.
REQ-008 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_rdata input DATA_W  single-port memory with 1-cycle synchronous read.
REQ-009 SHALL have ports busy output 1 and grant_id output 2  status (0 none, 1 init, 2 data, 3 fetch).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-011 SHALL, in IDLE with any req high at a clock edge, latch the winner's id, address, we and wdata, then enter ISSUE; otherwise stay in IDLE.
REQ-012 SHALL, in ISSUE, drive mem_en=1, mem_we/mem_addr/mem_wdata from the latched request for exactly one cycle, then enter RESP.
REQ-013 SHALL, in RESP, pulse only the winner's ack for one cycle and enter IDLE.
REQ-014 SHALL present mem_rdata on the winner's rdata during RESP for reads; rdata for writes SHALL be 0.
REQ-015 SHALL register each rdata output and hold it until that requester's next ack.
REQ-016 SHALL give a latency of: req sampled at edge k, ack high between edges k+2 and k+3.
REQ-017 SHALL treat init writes as mem_we=1, and fetch as mem_we=0.
REQ-018 SHALL ignore all req inputs in ISSUE and RESP; requesters hold req and fields stable until ack, and drop req at the edge where ack is sampled.
REQ-019 SHALL make init highest priority whenever several reqs are sampled together.
REQ-020 SHALL let a request arriving during ISSUE/RESP (including init) wait for IDLE; no preemption.
REQ-021 SHALL sustain back-to-back grants: one access every 3 cycles.
REQ-022 SHALL drive busy=1 in ISSUE and RESP; grant_id SHALL equal the latched winner in ISSUE/RESP, else 0.
REQ-023 SHALL truncate addresses to ADDR_W bits with no range check.

Reset
REQ-024 SHALL, while reset=0, force state IDLE, all acks 0, mem_en 0, mem_we 0, mem_addr/mem_wdata 0, rdata outputs 0, busy 0, grant_id 0, round-robin pointer to data.
REQ-025 SHALL drop an in-flight access on reset mid-ISSUE/RESP without ack; requesters reissue.

Configuration
REQ-026 SHALL, with ARB_RR_EN defined, arbitrate data vs fetch round-robin: the one not granted last wins a tie; pointer updates on every data/fetch grant.
REQ-027 SHALL, without ARB_RR_EN, use fixed priority data > fetch.

Structure
REQ-028 SHALL place the state enum and grant_id encodings in shared package mips_pkg.
REQ-029 SHALL be a single module; no sub-module is needed.

Verification
REQ-030 SHALL verify single fetch: mem[0x04]=0x2001000A, if_req addr 0x04 -> mem_en one cycle later, if_ack at k+2 with if_rdata=0x2001000A.
REQ-031 SHALL verify simultaneous init(0x10,0xDEADBEEF), d_req and if_req -> init first, then data, then fetch, acks 3 cycles apart.
REQ-032 SHALL verify d_req and if_req held together 4 grants -> without ARB_RR_EN D,D,D,D with fetch starved; with it D,F,D,F.
REQ-033 SHALL verify store then load: d_we=1 addr 0x20 wdata 0x12345678, then load 0x20 -> d_rdata=0x12345678, write-ack d_rdata=0.
REQ-034 SHALL verify reset=0 asserted during ISSUE -> no ack, mem_en=0 immediately, pending fetch re-granted normally after release.
